// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants, command codes and state encoding for pic_ctrl
package pic_pkg;

    // Register offsets from PORT_BASE
    localparam logic [15:0] OFS_CMD  = 16'd0;
    localparam logic [15:0] OFS_MASK = 16'd1;
    localparam logic [15:0] OFS_VEC  = 16'd2;

    // Command port codes: non-specific EOI, and read select 0000_101x
    localparam logic [7:0] CMD_EOI     = 8'h20;
    localparam logic [6:0] CMD_RSEL_HI = 7'b0000_101;

    // Reset constants
    localparam logic [7:0] IMR_RESET = 8'hFF;
    localparam logic [7:0] REG8_ZERO = 8'h00;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } pic_state_e;

    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } pic_rsel_e;

    // One-hot mask for an interrupt line index
    function automatic logic [7:0] line_mask(input logic [2:0] idx);
        line_mask = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/pic_ctrl_prio.sv
// rtl/pic_ctrl_prio.sv - 8-bit fixed-priority encoder, bit 0 highest
module pic_prio (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // Scan from the lowest priority up so the lowest set index wins
    always_comb begin
        valid_o = |req_i;
        idx_o   = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (req_i[n]) begin
                idx_o = n[2:0];
            end
        end
    end

endmodule

// File: rtl/pic_ctrl.sv
// rtl/pic_ctrl.sv - 8-line programmable interrupt controller with toggle handshake
module pic_ctrl
    import pic_pkg::*;
#(
    parameter logic [7:0]  BASE_VEC  = 8'h08,
    parameter logic [15:0] PORT_BASE = 16'h0020
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        locked,
    input  logic [7:0]  irq_in,
    input  logic [15:0] port,
    input  logic        port_clk,
    input  logic        port_w,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        intr,
    input  logic        intl,
    output logic [7:0]  irq
);

    pic_state_e state_q, state_d;

    logic [7:0] irq_s_q;
    logic [7:0] irq_p_q;
    logic       pclk_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [4:0] base_q, base_d;
    pic_rsel_e  rsel_q, rsel_d;
    logic       intr_q, intr_d;
    logic [7:0] irq_q, irq_d;

    logic [7:0] edges;
    logic       access, wr;
    logic       sel_cmd, sel_mask, sel_vec;
    logic       eoi;
    logic [7:0] pending;
    logic       pend_valid, isr_valid;
    logic [2:0] pend_idx, isr_idx;
    logic       eligible;
    logic       deliver;
    logic [7:0] deliver_mask, eoi_mask;

    pic_prio u_prio_pend (
        .req_i   (pending),
        .valid_o (pend_valid),
        .idx_o   (pend_idx)
    );

    pic_prio u_prio_isr (
        .req_i   (isr_q),
        .valid_o (isr_valid),
        .idx_o   (isr_idx)
    );

    // Edge and strobe detection, address decode and delivery eligibility
    always_comb begin
        edges    = irq_s_q & ~irq_p_q;
        access   = port_clk & ~pclk_q;
        wr       = access & port_w;
        sel_cmd  = (port == PORT_BASE + OFS_CMD);
        sel_mask = (port == PORT_BASE + OFS_MASK);
        sel_vec  = (port == PORT_BASE + OFS_VEC);
        eoi      = wr & sel_cmd & (port_o == CMD_EOI);
        pending  = irr_q & ~imr_q;
        eligible = pend_valid & (~isr_valid | (pend_idx < isr_idx));
    end

    // FSM state register; lock loss freezes everything including reset
    always_ff @(posedge clock) begin
        if (locked) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end
    end

    // FSM next state: leave IDLE on delivery, return once the core copies intr
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (intl == intr_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: a delivery happens only from IDLE
    always_comb begin
        deliver = (state_q == ST_IDLE) & eligible;
    end

    // Register next-state: new edges win over delivery clear, EOI spares the bit just delivered
    always_comb begin
        deliver_mask = deliver ? line_mask(pend_idx) : REG8_ZERO;
        eoi_mask     = (eoi & isr_valid) ? line_mask(isr_idx) : REG8_ZERO;

        irr_d  = (irr_q & ~deliver_mask) | edges;
        isr_d  = (isr_q | deliver_mask) & ~eoi_mask;
        imr_d  = imr_q;
        base_d = base_q;
        rsel_d = rsel_q;
        intr_d = intr_q ^ deliver;
        irq_d  = deliver ? {base_q, pend_idx} : irq_q;

        if (wr && sel_cmd && (port_o[7:1] == CMD_RSEL_HI)) begin
            rsel_d = port_o[0] ? RSEL_ISR : RSEL_IRR;
        end
        if (wr && sel_mask) begin
            imr_d = port_o;
        end
        if (wr && sel_vec) begin
            base_d = port_o[7:3];
        end
    end

    // Datapath registers and input synchronisers
    always_ff @(posedge clock) begin
        if (locked) begin
            if (!reset_n) begin
                irq_s_q <= REG8_ZERO;
                irq_p_q <= REG8_ZERO;
                pclk_q  <= 1'b0;
                irr_q   <= REG8_ZERO;
                isr_q   <= REG8_ZERO;
                imr_q   <= IMR_RESET;
                base_q  <= BASE_VEC[7:3];
                rsel_q  <= RSEL_IRR;
                intr_q  <= 1'b0;
                irq_q   <= BASE_VEC;
            end else begin
                irq_s_q <= irq_in;
                irq_p_q <= irq_s_q;
                pclk_q  <= port_clk;
                irr_q   <= irr_d;
                isr_q   <= isr_d;
                imr_q   <= imr_d;
                base_q  <= base_d;
                rsel_q  <= rsel_d;
                intr_q  <= intr_d;
                irq_q   <= irq_d;
            end
        end
    end

    // Side-effect-free register readback
    always_comb begin
        port_i = REG8_ZERO;
        if (sel_cmd) begin
            port_i = (rsel_q == RSEL_ISR) ? isr_q : irr_q;
        end else if (sel_mask) begin
            port_i = imr_q;
        end else if (sel_vec) begin
            port_i = {base_q, 3'b000};
        end
    end

    assign intr = intr_q;
    assign irq  = irq_q;

endmodule

// File: doc/pic_ctrl.md
PIC_CTRL -- requirements
Module: pic_ctrl

Interface
REQ-001 SHALL have parameter BASE_VEC, default 8'h08, reset value of the vector base register.
REQ-002 SHALL have parameter PORT_BASE, default 16'h0020, I/O address of the command port; mask port = PORT_BASE+1, vector port = PORT_BASE+2.
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 locked  input  1  PLL lock; when 0, all state holds, reset included.
REQ-006 irq_in  input  8  device request lines; bit 0 is highest priority.
REQ-007 port  input  16  I/O address from core.
REQ-008 port_clk  input  1  I/O strobe from core; an access occurs on its 0->1 transition.
REQ-009 port_w  input  1  1 = write access, 0 = read access.
REQ-010 port_o  input  8  write data from core.
REQ-011 port_i  output  8  read data to core; 8'h00 when port does not decode.
REQ-012 intr  output  1  request toggle to core; a pending request exists while intr != intl.
REQ-013 intl  input  1  core acknowledge toggle; core copies intr on acceptance.
REQ-014 irq  output  8  vector number presented with intr.

Function
REQ-015 SHALL register irq_in each cycle and set IRR[n] on a detected 0->1 edge of irq_in[n].
REQ-016 SHALL register port_clk and decode an access only in the cycle its rising edge is detected; exactly one access per edge.
REQ-017 Write PORT_BASE: value 8'h20 = non-specific EOI, clearing the highest-priority set ISR bit; value 8'b0000_101x = read select (0 -> IRR, 1 -> ISR); all other values ignored.
REQ-018 Write PORT_BASE+1 SHALL load IMR; write PORT_BASE+2 SHALL load vector base bits [7:3]; bits [2:0] ignored.
REQ-019 port_i SHALL be combinational: PORT_BASE -> IRR or ISR per read select; +1 -> IMR; +2 -> {base,3'b000}; reads have no side effects.
REQ-020 FSM states IDLE, WAIT_ACK; SHALL be in IDLE iff intr == intl.
REQ-021 In IDLE, with P = lowest index n where IRR[n] & ~IMR[n], and P strictly higher priority than every set ISR bit: next cycle irq <= {base,P[2:0]}, intr <= ~intr, IRR[P] <= 0, ISR[P] <= 1, state WAIT_ACK.
REQ-022 Delivery latency: 2 cycles from irq_in edge sampled to intr toggle when eligible.
REQ-023 In WAIT_ACK, SHALL hold irq and intr stable; return to IDLE the cycle after intl == intr; no timeout.
REQ-024 New edge on IRR[P] in the delivery cycle: set wins; bit stays pending.
REQ-025 EOI and delivery decision in the same cycle: decision uses pre-EOI ISR; EOI applied to ISR after the new ISR[P] set (ISR[P] excluded from that EOI).
REQ-026 EOI with ISR == 0 SHALL be a no-op; IMR changes affect only the next cycle's decision; an already-delivered request is not withdrawn.
REQ-027 Masked IRR bits SHALL remain pending and deliver once unmasked.

Reset
REQ-028 On reset: IRR=0, ISR=0, IMR=8'hFF, base=BASE_VEC[7:3], read select=IRR, intr=0, irq=BASE_VEC, state IDLE, edge/strobe registers=0.
REQ-029 Reset during WAIT_ACK SHALL abandon the request; the core's intl is expected to be reset to 0 by the same reset.

Structure
REQ-030 Shared package pic_pkg SHALL hold port offsets, EOI/read-select command codes, state encoding and reset constants.
REQ-031 Sub-module pic_prio: 8-bit fixed-priority encoder (valid, index), instantiated twice: pending and in-service.

Verification
REQ-032 Reset; write 8'hFE to 0x21; pulse irq_in[0] -> intr toggles 0->1 two cycles later, irq=8'h08, ISR=8'h01.
REQ-033 irq_in[3] and irq_in[1] rise in the same cycle, IMR=0 -> irq=8'h09 first; after ack and EOI (8'h20 to 0x20) -> irq=8'h0B.
REQ-034 ISR[2] set, irq_in[5] rises -> no toggle until EOI; then irq=8'h0D.
REQ-035 Write 8'h70 to 0x22, IMR=0, irq_in[7] -> irq=8'h77; intl not toggled for 100 cycles -> intr and irq stable.
REQ-036 Write 8'h0B to 0x20, then read 0x20 -> port_i equals ISR; port_clk held high for 10 cycles -> only one access.
REQ-037 Assert reset_n=0 in WAIT_ACK -> next cycle intr=0, IRR=ISR=0, IMR=8'hFF.
